// File: rtl/instruction_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_sequencer_if
// Purpose  : Bundles the request/stall inputs, the IR feedback and the
//            datapath control/status outputs of the instruction fetch
//            sequencer.
// Modports : master - the sequencer (drives datapath controls and status)
//            slave  - the datapath / controller side
// Signals  : Fetch_Req, Stall, IROut[15:0]                   -> sequencer
//            ARF_OutDSel[1:0], ARF_FunSel[2:0], ARF_RegSel[2:0],
//            Mem_CS, Mem_WR, IR_Write, IR_LH, Busy, Fetch_Done,
//            Instr_Valid, Opcode[5:0], Fetch_Count[15:0]      <- sequencer
// Revision : 1.0  initial release
// ============================================================================
interface instruction_fetch_sequencer_if;
    logic        Fetch_Req;
    logic        Stall;
    logic [15:0] IROut;
    logic [1:0]  ARF_OutDSel;
    logic [2:0]  ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        Mem_CS;
    logic        Mem_WR;
    logic        IR_Write;
    logic        IR_LH;
    logic        Busy;
    logic        Fetch_Done;
    logic        Instr_Valid;
    logic [5:0]  Opcode;
    logic [15:0] Fetch_Count;

    modport master (
        input  Fetch_Req, Stall, IROut,
        output ARF_OutDSel, ARF_FunSel, ARF_RegSel, Mem_CS, Mem_WR,
               IR_Write, IR_LH, Busy, Fetch_Done, Instr_Valid, Opcode,
               Fetch_Count
    );

    modport slave (
        output Fetch_Req, Stall, IROut,
        input  ARF_OutDSel, ARF_FunSel, ARF_RegSel, Mem_CS, Mem_WR,
               IR_Write, IR_LH, Busy, Fetch_Done, Instr_Valid, Opcode,
               Fetch_Count
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_sequencer
// Purpose  : Fetches one 16-bit instruction as two byte reads at PC into the
//            IR (low half, then high half), incrementing PC after each read.
//            Started by Fetch_Req, completion signalled by a Fetch_Done
//            pulse; keeps the opcode of the last fetch, a valid flag and a
//            completed-fetch counter.
// Ports    : clk_i  - datapath clock, rising edge
//            rst_i  - synchronous active-high reset
//            bus    - instruction_fetch_sequencer_if.master
// Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_sequencer (
    input  wire logic                     clk_i,
    input  wire logic                     rst_i,
    instruction_fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH_LO = 2'd1,
        S_FETCH_HI = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        instr_valid_q, instr_valid_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    // Raw decode of "perform a memory read + PC increment this cycle"
    logic        access_raw;
    logic        high_half;
    logic        access_en;

    // ------------------------------------------------------------------
    // State and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            instr_valid_q <= 1'b0;
            opcode_q      <= 6'h00;
            fetch_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            instr_valid_q <= instr_valid_d;
            opcode_q      <= opcode_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and access decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        instr_valid_d = instr_valid_q;
        opcode_d      = opcode_q;
        fetch_count_d = fetch_count_q;
        access_raw    = 1'b0;
        high_half     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Fetch_Req) begin
                    state_d       = S_FETCH_LO;
                    instr_valid_d = 1'b0;
                end
            end
            S_FETCH_LO: begin
                if (!bus.Stall) begin
                    access_raw = 1'b1;
                    state_d    = S_FETCH_HI;
                end
            end
            S_FETCH_HI: begin
                if (!bus.Stall) begin
                    access_raw = 1'b1;
                    high_half  = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                // IR is complete here, so the opcode is captured straight
                // from the fed-back IR on the edge leaving DONE.
                opcode_d      = bus.IROut[15:10];
                instr_valid_d = 1'b1;
                fetch_count_d = fetch_count_q + 16'd1;
                state_d       = bus.Fetch_Req ? S_FETCH_LO : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A reset cycle must not let the datapath complete a read or a PC
    // increment on the same edge that returns the sequencer to IDLE.
    assign access_en = access_raw & ~rst_i;

    // ------------------------------------------------------------------
    // Datapath control outputs (idle values unless reading)
    // ------------------------------------------------------------------
    assign bus.ARF_OutDSel = 2'b00;
    assign bus.ARF_FunSel  = access_en ? 3'b001 : 3'b000;
    assign bus.ARF_RegSel  = access_en ? 3'b100 : 3'b000;
    assign bus.Mem_CS      = ~access_en;
    assign bus.Mem_WR      = 1'b0;
    assign bus.IR_Write    = access_en;
    assign bus.IR_LH       = access_en & high_half;

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign bus.Busy        = (state_q == S_FETCH_LO) || (state_q == S_FETCH_HI);
    assign bus.Fetch_Done  = (state_q == S_DONE);
    assign bus.Instr_Valid = instr_valid_q;
    assign bus.Opcode      = opcode_q;
    assign bus.Fetch_Count = fetch_count_q;

endmodule
`default_nettype wire
